// File: rtl/sim_run_ctrl.sv
// End-of-simulation run controller: ends the run on halt (pass), on timeout, or after an error drain window.
// Optional define WATCHDOG_PROGRESS_EN turns the timeout into a no-retirement watchdog reloaded by commit_i.
module sim_run_ctrl #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned RET_WIDTH      = 8,
  parameter int unsigned NUM_ERR        = 3,
  parameter int unsigned TO_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned HALT_MODE      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*RET_WIDTH-1:0]   halt_i,
  input  logic [NUM_CH*RET_WIDTH-1:0]   commit_i,
  input  logic [NUM_ERR-1:0]            err_i,
  output logic [1:0]                    state_o,
  output logic                          finish_o,
  output logic                          pass_o,
  output logic                          timeout_o,
  output logic                          error_o,
  output logic [NUM_CH-1:0]             halted_o,
  output logic [TO_W-1:0]               cycles_o
);

  localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TO_W-1:0] TC_INIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [DC_W-1:0] DC_INIT = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   tc;
  logic [DC_W-1:0]   dc;
  logic [NUM_CH-1:0] ch_halt;
  logic              halt_met;
  logic              err_any;
  logic              progress;

  always_comb begin
    ch_halt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_halt[c] = |halt_i[c*RET_WIDTH +: RET_WIDTH];
    end
  end

  always_comb begin
    if (HALT_MODE == 0) halt_met = |ch_halt;
    else                halt_met = &(halted_o | ch_halt);
  end

  // An X/Z anywhere on the error lanes counts as an error, not as quiet.
  always_comb err_any = ((|err_i) !== 1'b0);

`ifdef WATCHDOG_PROGRESS_EN
  always_comb progress = |commit_i;
`else
  logic unused_commit;
  always_comb unused_commit = ^commit_i;
  always_comb progress = 1'b0;
`endif

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      finish_o  <= 1'b0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
      error_o   <= 1'b0;
      halted_o  <= '0;
      cycles_o  <= '0;
      tc        <= TC_INIT;
      dc        <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (cycles_o != '1) cycles_o <= cycles_o + TO_W'(1);
          halted_o <= halted_o | ch_halt;
          if (halt_met) begin
            state    <= ST_DONE;
            pass_o   <= 1'b1;
            finish_o <= 1'b1;
          end else if (tc == '0) begin
            state     <= ST_DONE;
            timeout_o <= 1'b1;
            finish_o  <= 1'b1;
          end else if (err_any) begin
            state <= ST_DRAIN;
            dc    <= DC_INIT;
          end else if (progress) begin
            tc <= TC_INIT;
          end else begin
            tc <= tc - TO_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cycles_o != '1) cycles_o <= cycles_o + TO_W'(1);
          if (dc == '0) begin
            state    <= ST_DONE;
            error_o  <= 1'b1;
            finish_o <= 1'b1;
          end else begin
            dc <= dc - DC_W'(1);
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

endmodule
